// File: rtl/rs_chien_root_seq.sv
// Chien-search root sequencer: streams alpha powers and their GF(2^m) values,
// ROOTS_PER_CYCLE lanes per beat, for one codeword at a time.
module rs_chien_root_seq #(
   parameter int SYMB_WIDTH      = 8,
   parameter int N_LEN           = 255,
   parameter int ROOTS_PER_CYCLE = 4,
   parameter int LEN_W           = $clog2(N_LEN + 1)
) (
   input  logic                                    aclk,
   input  logic                                    aresetn,
   input  logic                                    start_vld,
   output logic                                    start_rdy,
   input  logic [SYMB_WIDTH-1:0]                   start_pwr,
   input  logic [LEN_W-1:0]                        start_len,
   input  logic                                    abort,
   output logic                                    out_vld,
   input  logic                                    out_rdy,
   output logic [ROOTS_PER_CYCLE*SYMB_WIDTH-1:0]   out_alpha,
   output logic [ROOTS_PER_CYCLE*SYMB_WIDTH-1:0]   out_root,
   output logic [ROOTS_PER_CYCLE-1:0]              out_lane_vld,
   output logic                                    out_sop,
   output logic                                    out_eop,
   output logic                                    busy
);

   localparam int M = SYMB_WIDTH;
   localparam int Q = (1 << M) - 1;
   localparam int R = ROOTS_PER_CYCLE;
   localparam logic [M:0]       Q_W  = (M + 1)'(Q);
   // Offsets are pre-reduced mod Q at elaboration, so every runtime adder
   // sees two operands below Q and needs only one conditional subtract.
   localparam logic [M:0]       STEP = (M + 1)'(R % Q);
   localparam logic [LEN_W-1:0] R_L  = LEN_W'(R);
   localparam logic [LEN_W-1:0] N_L  = LEN_W'(N_LEN);

   typedef logic [Q-1:0][M-1:0] lut_t;

   function automatic int prim_poly(input int m);
      case (m)
         3:       return 'hB;
         4:       return 'h13;
         5:       return 'h25;
         6:       return 'h43;
         7:       return 'h89;
         9:       return 'h211;
         10:      return 'h409;
         11:      return 'h805;
         12:      return 'h1053;
         13:      return 'h201B;
         14:      return 'h4443;
         15:      return 'h8003;
         16:      return 'h1100B;
         default: return 'h11D;
      endcase
   endfunction

   localparam int POLY = prim_poly(M);

   function automatic lut_t build_lut();
      lut_t       t;
      logic [M:0] v;
      v = (M + 1)'(1);
      for (int p = 0; p < Q; p++) begin
         t[p] = v[M-1:0];
         v    = {v[M-1:0], 1'b0};
         if (v[M]) v = v ^ (M + 1)'(POLY);
      end
      return t;
   endfunction

   localparam lut_t ALPHA_LUT = build_lut();

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [M-1:0]     base_q, base_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             sop_q, sop_d;

   logic             run;
   logic             beat_hs;
   logic             start_acc;
   logic [LEN_W-1:0] eff_len;
   logic [M:0]       base_sum;
   logic [M:0]       base_red;

   assign run       = (state_q == RUN);
   assign busy      = run;
   assign out_vld   = run;
   assign out_sop   = run & sop_q;
   assign out_eop   = run & (rem_q <= R_L);
   assign beat_hs   = out_vld & out_rdy;
   assign start_rdy = ~abort & (~run | (beat_hs & out_eop));
   assign start_acc = start_vld & start_rdy;
   assign eff_len   = (start_len > N_L) ? N_L : start_len;
   assign base_sum  = {1'b0, base_q} + STEP;
   assign base_red  = (base_sum >= Q_W) ? base_sum - Q_W : base_sum;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      rem_d   = rem_q;
      sop_d   = sop_q;
      if (abort) begin
         state_d = IDLE;
         base_d  = '0;
         rem_d   = '0;
         sop_d   = 1'b0;
      end else begin
         if (beat_hs) begin
            if (out_eop) begin
               state_d = IDLE;
               base_d  = '0;
               rem_d   = '0;
               sop_d   = 1'b0;
            end else begin
               base_d = base_red[M-1:0];
               rem_d  = rem_q - R_L;
               sop_d  = 1'b0;
            end
         end
         // A zero-length request is consumed without leaving IDLE.
         if (start_acc && (eff_len != '0)) begin
            state_d = RUN;
            base_d  = start_pwr;
            rem_d   = eff_len;
            sop_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         base_q  <= '0;
         rem_q   <= '0;
         sop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         rem_q   <= rem_d;
         sop_q   <= sop_d;
      end
   end

   for (genvar i = 0; i < R; i++) begin : g_lane
      localparam logic [M:0] OFF = (M + 1)'(i % Q);
      logic [M:0]   sum;
      logic [M:0]   red;
      logic [M-1:0] pow;
      logic         vld;

      assign sum = {1'b0, base_q} + OFF;
      assign red = (sum >= Q_W) ? sum - Q_W : sum;
      assign pow = red[M-1:0];
      assign vld = run & (rem_q > LEN_W'(i));

      assign out_lane_vld[i]      = vld;
      assign out_alpha[i*M +: M]  = vld ? pow : '0;
      assign out_root[i*M +: M]   = vld ? ALPHA_LUT[pow] : '0;
   end

endmodule
